// File: rtl/tea_pkg.sv
// Shared constants, state type and counter helpers for the TEA sequencer.
package tea_pkg;

    localparam int unsigned ROUNDS = 32;
    localparam logic [31:0] DELTA  = 32'h9E3779B9;
    localparam int unsigned KEY_W  = 128;
    localparam int unsigned BLK_W  = 64;
    localparam int unsigned CNT_W  = $clog2((KEY_W > BLK_W) ? KEY_W : BLK_W);
    localparam int unsigned RND_W  = $clog2(ROUNDS);

    typedef enum logic [2:0] {
        StIdle,
        StKeyRx,
        StBlkRx,
        StLoad,
        StRound,
        StCapture,
        StTx
    } tea_state_e;

    // Terminal value of the bit counter for a transfer of n bits.
    function automatic logic [CNT_W-1:0] last_bit(input int unsigned n);
        return CNT_W'(n - 1);
    endfunction

endpackage

// File: rtl/tea_shift_reg.sv
// Shift register: serial-in at the LSB, parallel load, MSB-first serial out via q_o.
module tea_shift_reg #(
    parameter int unsigned Width = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             sin_i,
    input  logic [Width-1:0] pdata_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] q_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= pdata_i;
        end else if (shift_i) begin
            q_q <= {q_q[Width-2:0], sin_i};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/tea_seq_ctrl.sv
// TEA sequencer: serial key/block reception, round strobes with running sum, serial result return.
module tea_seq_ctrl
    import tea_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_key_update,
    input  logic             i_calculate,
    input  logic             i_rx,
    output logic             o_tx,
    output logic             o_ready,
    output logic [KEY_W-1:0] o_key,
    output logic [BLK_W-1:0] o_blk,
    output logic             o_dp_load,
    output logic             o_dp_step,
    output logic [31:0]      o_dp_sum,
    input  logic [BLK_W-1:0] i_dp_result
);

    tea_state_e       state_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [RND_W-1:0] round_cnt_q;
    logic [31:0]      sum_q;

    logic [KEY_W-1:0] rx_q;
    logic [KEY_W-1:0] rx_next;
    logic [BLK_W-1:0] tx_q;
    logic             rx_shift;
    logic             tx_load;
    logic             tx_shift;

    logic             unused_rx_msb;
    logic [BLK_W-2:0] unused_tx_lsbs;

    assign rx_shift = (state_q == StKeyRx) || (state_q == StBlkRx);
    assign tx_load  = (state_q == StCapture);
    assign tx_shift = (state_q == StTx);

    // Value the RX register holds after this edge; lets the final bit commit in the same cycle.
    assign rx_next = {rx_q[KEY_W-2:0], i_rx};

    tea_shift_reg #(
        .Width (KEY_W)
    ) u_rx_sr (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (1'b0),
        .shift_i (rx_shift),
        .sin_i   (i_rx),
        .pdata_i ('0),
        .q_o     (rx_q)
    );

    tea_shift_reg #(
        .Width (BLK_W)
    ) u_tx_sr (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (tx_load),
        .shift_i (tx_shift),
        .sin_i   (1'b0),
        .pdata_i (i_dp_result),
        .q_o     (tx_q)
    );

    assign o_tx           = tx_shift && tx_q[BLK_W-1];
    assign o_dp_sum       = sum_q;
    assign unused_rx_msb  = rx_q[KEY_W-1];
    assign unused_tx_lsbs = tx_q[BLK_W-2:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            o_ready     <= 1'b1;
            o_dp_load   <= 1'b0;
            o_dp_step   <= 1'b0;
            o_key       <= '0;
            o_blk       <= '0;
            sum_q       <= '0;
            bit_cnt_q   <= '0;
            round_cnt_q <= '0;
        end else begin
            o_dp_load <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    bit_cnt_q <= '0;
                    // Key update has priority; a simultaneous calculate request is dropped.
                    if (i_key_update) begin
                        state_q <= StKeyRx;
                        o_ready <= 1'b0;
                    end else if (i_calculate) begin
                        state_q <= StBlkRx;
                        o_ready <= 1'b0;
                    end
                end
                StKeyRx: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == last_bit(KEY_W)) begin
                        o_key     <= rx_next;
                        bit_cnt_q <= '0;
                        o_ready   <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                StBlkRx: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == last_bit(BLK_W)) begin
                        o_blk     <= rx_next[BLK_W-1:0];
                        o_dp_load <= 1'b1;
                        bit_cnt_q <= '0;
                        state_q   <= StLoad;
                    end
                end
                StLoad: begin
                    sum_q       <= DELTA;
                    round_cnt_q <= '0;
                    o_dp_step   <= 1'b1;
                    state_q     <= StRound;
                end
                StRound: begin
                    sum_q       <= sum_q + DELTA;
                    round_cnt_q <= round_cnt_q + 1'b1;
                    if (round_cnt_q == RND_W'(ROUNDS - 1)) begin
                        o_dp_step <= 1'b0;
                        state_q   <= StCapture;
                    end
                end
                StCapture: begin
                    bit_cnt_q <= '0;
                    state_q   <= StTx;
                end
                StTx: begin
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == last_bit(BLK_W)) begin
                        bit_cnt_q <= '0;
                        o_ready   <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tea_seq_ctrl.sv
// Directed/randomised bench for tea_seq_ctrl with a behavioural TEA datapath and cipher reference.
module tb_tea_seq_ctrl;

    localparam int unsigned TB_ROUNDS = 32;
    localparam logic [31:0] TB_DELTA  = 32'h9E3779B9;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_key_update;
    logic         i_calculate;
    logic         i_rx;
    logic         o_tx;
    logic         o_ready;
    logic [127:0] o_key;
    logic [63:0]  o_blk;
    logic         o_dp_load;
    logic         o_dp_step;
    logic [31:0]  o_dp_sum;
    logic [63:0]  i_dp_result;

    int           checks = 0;
    int           errors = 0;
    logic [127:0] model_key = '0;

    always #5 clk = ~clk;

    tea_seq_ctrl dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_key_update (i_key_update),
        .i_calculate  (i_calculate),
        .i_rx         (i_rx),
        .o_tx         (o_tx),
        .o_ready      (o_ready),
        .o_key        (o_key),
        .o_blk        (o_blk),
        .o_dp_load    (o_dp_load),
        .o_dp_step    (o_dp_step),
        .o_dp_sum     (o_dp_sum),
        .i_dp_result  (i_dp_result)
    );

    // Round datapath stand-in: holds v0/v1 and applies one TEA round per step strobe.
    logic [31:0] dv0 = '0;
    logic [31:0] dv1 = '0;
    logic [31:0] nv0;
    always @(posedge clk) begin
        if (o_dp_load) begin
            dv0 <= o_blk[63:32];
            dv1 <= o_blk[31:0];
        end else if (o_dp_step) begin
            nv0 = dv0 + (((dv1 << 4) + o_key[127:96]) ^ (dv1 + o_dp_sum)
                         ^ ((dv1 >> 5) + o_key[95:64]));
            dv1 <= dv1 + (((nv0 << 4) + o_key[63:32]) ^ (nv0 + o_dp_sum)
                          ^ ((nv0 >> 5) + o_key[31:0]));
            dv0 <= nv0;
        end
    end
    assign i_dp_result = {dv0, dv1};

    function automatic logic [63:0] tea_ref(input logic [127:0] k, input logic [63:0] p);
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] s;
        v0 = p[63:32];
        v1 = p[31:0];
        s  = '0;
        for (int r = 0; r < TB_ROUNDS; r++) begin
            s  = s + TB_DELTA;
            v0 = v0 + (((v1 << 4) + k[127:96]) ^ (v1 + s) ^ ((v1 >> 5) + k[95:64]));
            v1 = v1 + (((v0 << 4) + k[63:32]) ^ (v0 + s) ^ ((v0 >> 5) + k[31:0]));
        end
        return {v0, v1};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k, input logic with_calc);
        i_key_update = 1'b1;
        i_calculate  = with_calc;
        tick();
        i_key_update = 1'b0;
        i_calculate  = 1'b0;
        chk("key_busy", o_ready, 1'b0);
        for (int i = 0; i < 128; i++) begin
            i_rx = k[127-i];
            tick();
            chk("key_no_load", o_dp_load, 1'b0);
            if (i < 127) begin
                chk("key_hold", o_key, model_key);
            end else begin
                chk("key_commit", o_key, k);
                chk("key_ready", o_ready, 1'b1);
            end
        end
        i_rx      = 1'b0;
        model_key = k;
    endtask

    // Runs one block after its start edge; returns early if a reset is injected at round rst_at.
    task automatic block_body(input logic [63:0] blk, input logic chain, input int rst_at);
        logic [63:0] ct;
        logic [31:0] sum_exp;
        ct = tea_ref(model_key, blk);
        i_calculate = 1'b0;
        for (int i = 0; i < 64; i++) begin
            i_rx = blk[63-i];
            tick();
            chk("rx_ready", o_ready, 1'b0);
            if (i < 63) chk("rx_no_load", o_dp_load, 1'b0);
        end
        i_rx = 1'b0;
        chk("load_strobe", o_dp_load, 1'b1);
        chk("load_blk", o_blk, blk);
        chk("load_no_step", o_dp_step, 1'b0);
        for (int k = 0; k < TB_ROUNDS; k++) begin
            tick();
            sum_exp = TB_DELTA * (k + 1);
            chk("round_step", o_dp_step, 1'b1);
            chk("round_sum", o_dp_sum, sum_exp);
            chk("round_no_load", o_dp_load, 1'b0);
            if (k == TB_ROUNDS - 1) chk("round_last_sum", o_dp_sum, 32'hC6EF3720);
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1;
                chk("arst_step", o_dp_step, 1'b0);
                chk("arst_key", o_key, 128'h0);
                chk("arst_ready", o_ready, 1'b1);
                chk("arst_sum", o_dp_sum, 32'h0);
                tick();
                rst          = 1'b0;
                model_key    = '0;
                i_calculate  = 1'b0;
                i_key_update = 1'b0;
                tick();
                chk("arst_idle", o_ready, 1'b1);
                return;
            end
            // Start requests are ignored while busy.
            i_calculate  = 1'($urandom_range(0, 1));
            i_key_update = 1'($urandom_range(0, 1));
        end
        i_calculate  = 1'b0;
        i_key_update = 1'b0;
        tick();
        chk("capture_step", o_dp_step, 1'b0);
        chk("capture_tx", o_tx, 1'b0);
        for (int b = 0; b < 64; b++) begin
            tick();
            chk("tx_bit", o_tx, ct[63-b]);
            chk("tx_ready", o_ready, 1'b0);
            if (b == 63 && chain) i_calculate = 1'b1;
        end
        tick();
        chk("done_ready", o_ready, 1'b1);
        chk("done_tx", o_tx, 1'b0);
    endtask

    task automatic start_block();
        i_calculate = 1'b1;
        tick();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] rk;
        logic [63:0]  rb;
        rst          = 1'b1;
        i_key_update = 1'b0;
        i_calculate  = 1'b0;
        i_rx         = 1'b0;
        tick();
        tick();
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_tx", o_tx, 1'b0);
        chk("rst_key", o_key, 128'h0);
        chk("rst_blk", o_blk, 64'h0);
        chk("rst_load", o_dp_load, 1'b0);
        chk("rst_step", o_dp_step, 1'b0);
        chk("rst_sum", o_dp_sum, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("idle_ready", o_ready, 1'b1);
            chk("idle_tx", o_tx, 1'b0);
            chk("idle_key", o_key, 128'h0);
        end

        // Zero key, zero block: known ciphertext.
        chk("ref_zero", tea_ref(128'h0, 64'h0), 64'h41EA3A0A94BAA940);
        start_block();
        block_body(64'h0, 1'b0, -1);

        load_key(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b0);
        start_block();
        block_body(64'h0123456789ABCDEF, 1'b1, -1);
        // Chained start: ready high for one cycle, then the next block begins.
        tick();
        i_calculate = 1'b0;
        chk("chain_busy", o_ready, 1'b0);
        rb = {$urandom, $urandom};
        block_body(rb, 1'b0, -1);

        // Key update wins over simultaneous calculate.
        rk = {$urandom, $urandom, $urandom, $urandom};
        load_key(rk, 1'b1);
        tick();
        chk("both_idle", o_ready, 1'b1);
        chk("both_no_load", o_dp_load, 1'b0);

        rb = {$urandom, $urandom};
        start_block();
        block_body(rb, 1'b0, -1);

        // Reset mid-round, then a full fresh transaction.
        rb = {$urandom, $urandom};
        start_block();
        block_body(rb, 1'b0, 10);
        rk = {$urandom, $urandom, $urandom, $urandom};
        load_key(rk, 1'b0);
        rb = {$urandom, $urandom};
        start_block();
        block_body(rb, 1'b0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
